// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit's AXI-Lite master.
// The optional load extraction is controlled by the LSU_LOADEXT_EN macro in lsu_axil_master.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-enable pattern of an access at offset 0; funct3[1:0] encodes the size.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        misaligned = funct3[1] ? (offset != 2'd0) : (funct3[0] & offset[0]);
    endfunction

endpackage

// File: rtl/lsu_axil_master_if.sv
// AXI-Lite channel bundle between the LSU (master) and the memory responder (slave).
// Handshake: a beat transfers on a rising clk edge where both valid and ready are high.
interface lsu_axil_master_if;
    logic        mem_awvalid;
    logic        mem_awready;
    logic [31:0] mem_awaddr;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_bvalid;
    logic        mem_bready;
    logic [1:0]  mem_bresp;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [1:0]  mem_rresp;
    logic [31:0] mem_rdata;

    modport master (
        output mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
               mem_arvalid, mem_araddr, mem_rready,
        input  mem_awready, mem_wready, mem_bvalid, mem_bresp,
               mem_arready, mem_rvalid, mem_rresp, mem_rdata
    );

    modport slave (
        input  mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
               mem_arvalid, mem_araddr, mem_rready,
        output mem_awready, mem_wready, mem_bvalid, mem_bresp,
               mem_arready, mem_rvalid, mem_rresp, mem_rdata
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Combinational RV32 load extraction: selects the addressed byte/halfword and extends it.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] raw,
    output logic [31:0] data
);
    logic [31:0] shifted;
    assign shifted = raw >> {offset, 3'b000};

    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/lsu_axil_master.sv
// Single-outstanding RV32 load/store unit driving an AXI-Lite master port.
// Define LSU_LOADEXT_EN to extract and extend sub-word loads here instead of in the responder.
module lsu_axil_master
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    lsu_axil_master_if.master  bus,
    output lsu_state_e         dbg_state
);
    lsu_state_e  state_q, state_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [31:0] araddr_q, awaddr_q, wdata_q, rdata_q, load_data;
    logic [3:0]  wstrb_q;
    logic [1:0]  resp_q;
    logic        misal_q, accept, req_misal;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_misal = misaligned(req_funct3, req_addr[1:0]);

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        case (state_q)
            IDLE: if (accept) begin
                if (req_misal) begin
                    state_d = RESP;
                end else if (req_we) begin
                    state_d   = WR_REQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                end else begin
                    state_d   = RD_ADDR;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                end
            end
            RD_ADDR: if (bus.mem_arready) begin
                arvalid_d = 1'b0;
                state_d   = RD_DATA;
            end
            RD_DATA: if (bus.mem_rvalid) begin
                rready_d = 1'b0;
                state_d  = RESP;
            end
            WR_REQ: begin
                if (awvalid_q && bus.mem_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.mem_wready)   wvalid_d  = 1'b0;
                // A channel whose valid is already low completed its handshake earlier.
                if ((!awvalid_q || bus.mem_awready) && (!wvalid_q || bus.mem_wready))
                    state_d = WR_RESP;
            end
            WR_RESP: if (bus.mem_bvalid) begin
                bready_d = 1'b0;
                state_d  = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            misal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            if (accept) begin
                misal_q <= req_misal;
                resp_q  <= RESP_OKAY;
                rdata_q <= '0;
                if (!req_misal && !req_we) araddr_q <= req_addr;
                if (!req_misal && req_we) begin
                    awaddr_q <= {req_addr[31:2], 2'b00};
                    wdata_q  <= req_wdata << {req_addr[1:0], 3'b000};
                    wstrb_q  <= size_mask(req_funct3) << req_addr[1:0];
                end
            end
            if (state_q == RD_DATA && bus.mem_rvalid) begin
                rdata_q <= bus.mem_rdata;
                resp_q  <= bus.mem_rresp;
            end
            if (state_q == WR_RESP && bus.mem_bvalid) resp_q <= bus.mem_bresp;
        end
    end

`ifdef LSU_LOADEXT_EN
    logic [2:0] f3_q;
    logic [1:0] off_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q  <= '0;
            off_q <= '0;
        end else if (accept) begin
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
        end
    end

    lsu_load_ext u_load_ext (
        .funct3 (f3_q),
        .offset (off_q),
        .raw    (rdata_q),
        .data   (load_data)
    );
`else
    assign load_data = rdata_q;
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && (misal_q || resp_q != RESP_OKAY);
    assign resp_rdata = resp_valid ? load_data : 32'd0;
    assign dbg_state  = state_q;

    assign bus.mem_arvalid = arvalid_q;
    assign bus.mem_araddr  = araddr_q;
    assign bus.mem_rready  = rready_q;
    assign bus.mem_awvalid = awvalid_q;
    assign bus.mem_awaddr  = awaddr_q;
    assign bus.mem_wvalid  = wvalid_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = {4'b0000, wstrb_q};
    assign bus.mem_bready  = bready_q;
endmodule

// File: doc/lsu_axil_master.md
LSU_AXIL_MASTER -- requirements
Module: lsu_axil_master

Interface
REQ-001 Clock is clk; reset is rst, synchronous, active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  core load/store request.
REQ-005 req_ready  out  1  high only in IDLE; a request is taken on req_valid&&req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32 size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, LSB-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse; the core does not backpressure it.
REQ-011 resp_rdata  out  32  load result, valid with resp_valid; 0 for stores.
REQ-012 resp_err  out  1  misaligned access or nonzero bresp/rresp, valid with resp_valid.
REQ-013 mem_awvalid/mem_awready/mem_awaddr  out/in/out  1/1/32  write address channel.
REQ-014 mem_wvalid/mem_wready  out/in  1/1  write data handshake.
REQ-015 mem_wdata  out  32  lane-shifted store data.
REQ-016 mem_wstrb  out  8  byte strobes; bits [7:4] always 0.
REQ-017 mem_bvalid/mem_bready/mem_bresp  in/out/in  1/1/2  write response channel.
REQ-018 mem_arvalid/mem_arready/mem_araddr  out/in/out  1/1/32  read address channel.
REQ-019 mem_rvalid/mem_rready/mem_rresp/mem_rdata  in/out/in/in  1/1/2/32  read data channel.

Function
REQ-020 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP. All AXI outputs are registered.
REQ-021 On request acceptance, latch address, funct3, we and data.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) goes straight to RESP with resp_err=1.
  - No AXI channel is touched for a misaligned access.
REQ-022 Aligned load: IDLE -> RD_ADDR.
  - mem_arvalid=1 and mem_araddr=req_addr from the next cycle.
  - arvalid stays high until mem_arready is sampled high, then drops.
  - Then enter RD_DATA.
REQ-023 mem_rready is 1 throughout RD_ADDR and RD_DATA, because the responder pulses rvalid for one cycle.
  - On mem_rvalid in RD_DATA, capture rdata and rresp, then enter RESP.
REQ-024 Aligned store: IDLE -> WR_REQ.
  - mem_awvalid, mem_wvalid and mem_bready are all asserted in the same cycle.
  - awaddr = addr with low 2 bits cleared.
  - wdata = wdata << 8*addr[1:0].
  - wstrb = {4'b0, (B:4'b0001, H:4'b0011, W:4'b1111) << addr[1:0]}.
REQ-025 In WR_REQ, each of awvalid and wvalid drops independently after its own handshake.
  - Once both handshakes are done, enter WR_RESP; bready stays high.
  - On mem_bvalid, capture bresp and enter RESP.
  - A bvalid seen before both handshakes complete is ignored.
REQ-026 RESP lasts exactly one cycle with resp_valid=1, then returns to IDLE; resp_err = (captured resp != 2'b00).
REQ-027 Latency with zero-wait responder and rvalid at cycle k after the AR handshake: resp_valid at cycle k+1.
  - No new request is accepted before the cycle after resp_valid.

Reset
REQ-028 On rst: state=IDLE, and every output is 0 except req_ready=1.
  - This covers all valid signals, all ready signals, mem_wstrb and resp_*.
  - Reset mid-transaction abandons it with no resp_valid, and all valids are low the cycle after rst.

Configuration
REQ-029 LSU_LOADEXT_EN defined: resp_rdata is the addr[1:0]-selected byte or halfword, sign-extended (funct3 0/1) or zero-extended (4/5); W passes through.
REQ-030 LSU_LOADEXT_EN undefined: resp_rdata is the raw captured mem_rdata, and the responder performs extraction.

Structure
REQ-031 Package lsu_pkg holds:
  - the FSM state enum;
  - funct3 constants F3_B/H/W/BU/HU;
  - AXI resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
REQ-032 Combinational sub-module lsu_load_ext(funct3, offset, raw -> data) is instantiated only under LSU_LOADEXT_EN.

Verification
REQ-033 LW 0x8000_0004, arready after 2 cycles, rvalid rdata=0xDEADBEEF -> one resp_valid, rdata 0xDEADBEEF, err 0, araddr 0x8000_0004.
REQ-034 LB 0x8000_0003, raw rdata 0x80FF_0000 -> rdata 0xFFFF_FF80 with EN; 0x80FF_0000 without EN.
REQ-035 SH 0x8000_0002 data 0x1234ABCD, awready 3 cycles after wready -> wstrb 0x0C, wdata 0xABCD_0000, awaddr 0x8000_0000; resp after bvalid.
REQ-036 LW 0x8000_0001 -> resp_err=1 within 2 cycles, arvalid never asserted.
REQ-037 rst asserted while arvalid=1 -> arvalid 0 next cycle, no resp_valid, req_ready=1.
REQ-038 SW with bresp=2'b10 -> resp_valid with resp_err=1, rdata 0.
